float2int_serial: RTL
=====================

# float2int_serial

Sequential decoder that expands a packed small-float code (3-bit exponent E, 4-bit mantissa M) back into the 11-bit unsigned integer B. It is the inverse of the combinational `int2float` encoder. It sits on the consumer side of the float-coded datapath, behind a valid/ready handshake. The shift is done serially, one bit position per cycle, so area stays small. Only the low E bits of the original integer are lost, which is inherent to the encoding.

## Interface
- `MW`, default 4: mantissa width.
- `EW`, default 3: exponent width.
- `BW`, default 11: integer width; must equal MW + 2^EW − 1.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input code valid.
- `in_ready` out 1: block can accept a code.
- `in_e` in EW: exponent E.
- `in_m` in MW: mantissa M.
- `out_valid` out 1: decoded result valid.
- `out_ready` in 1: consumer accepts result.
- `out_b` out BW: decoded integer, M << E, zero-extended.
- `out_noncanon` out 1: input was non-canonical, i.e. E > 0 and M[MW−1] = 0.

## Operation
- **Decoding rule.** B = M << E, zero-extended to BW bits.
  - No overflow is possible: the maximum is 15 << 7 = 1920 < 2048.
- **Canonical form.** The encoder emits E = max(0, msb(B) − 3) and M = B >> E.
  - A code with E > 0 must therefore have M[3] = 1.
  - A code with E > 0 and M[3] = 0 (including M = 0) is still decoded by the rule, and `out_noncanon` = 1.
- **FSM states:**
  - **IDLE:** `in_ready` = 1.
    - On `in_valid` & `in_ready`: load acc = {0, in_m} and cnt = in_e, and latch the noncanon flag.
    - Next state is DONE if in_e = 0, else SHIFT.
  - **SHIFT:** each cycle acc <= acc << 1 and cnt <= cnt − 1.
    - When cnt = 1, the final shift lands and the next state is DONE.
  - **DONE:** `out_valid` = 1, with `out_b` = acc and `out_noncanon` = flag.
    - On `out_ready`, go to IDLE.
- `in_ready` is asserted only in IDLE. `in_valid` is ignored in SHIFT and DONE; no input is consumed there.
- `out_b` and `out_noncanon` are held stable throughout DONE, regardless of `out_ready` or input activity.
- After the DONE handshake, `out_b` keeps its last value (don't-care), but `out_valid` drops.
- **Reset mid-operation** (SHIFT or DONE): the in-flight transaction is dropped, with no partial output.

## Timing
- **Reset values:**
  - state = IDLE.
  - `in_ready` = 1 in the cycle after reset deassert; it is 0 while `rst` = 1.
  - `out_valid` = 0, `out_b` = 0, `out_noncanon` = 0; acc = 0, cnt = 0.
- **Latency.** If input is accepted at edge t, `out_valid` rises at edge t + E + 1.
  - E = 0 gives 1 cycle; E = 7 gives 8 cycles.
- **Throughput.** At most one code per E + 2 cycles when `out_ready` is tied high.
  - The IDLE cycle after DONE is mandatory.
  - Accept and output never occur in the same cycle.
- **Backpressure.** DONE lasts until `out_ready` = 1, with no upper bound.
- **Simultaneous `rst` and handshake.** `rst` wins; the handshake is not counted.
- **Handshake rules.** Inputs are sampled only on the accepting edge. `in_e` and `in_m` may change freely afterwards.

## Structure
- Shared package `float_fmt_pkg` holds:
  - the localparams MW, EW, BW and a static check that BW = MW + 2^EW − 1;
  - the FSM state enum (`ST_IDLE`, `ST_SHIFT`, `ST_DONE`);
  - a `float_code_t` packed struct {e, m}, reusable by the encoder side.
- Single module; no sub-module is natural.
  - Shift register, down-counter and FSM share the same control and stay inline.

## Test plan
- **E = 0 path.** Accept E = 0, M = 9 with `out_ready` = 1.
  - Expect `out_valid` at t + 1, `out_b` = 9, `out_noncanon` = 0, `in_ready` = 1 again at t + 2.
- **Maximum shift.** E = 7, M = 15.
  - Expect `out_b` = 1920 at t + 8, `in_ready` = 0 on cycles t + 1 … t + 8.
- **Non-canonical code.** E = 3, M = 5.
  - Expect `out_b` = 40 at t + 4 and `out_noncanon` = 1.
  - Also E = 2, M = 0: expect `out_b` = 0, `out_noncanon` = 1.
- **Backpressure.** E = 4, M = 12 with `out_ready` low for 5 cycles after `out_valid`, while new codes are driven on the input.
  - Expect `out_b` = 192 held stable, `in_ready` = 0, and no input consumed.
  - Expect IDLE on the cycle after `out_ready` rises.
- **Reset mid-operation.** Assert `rst` during SHIFT of E = 6, M = 8.
  - Next cycle: `out_valid` = 0, `out_b` = 0, IDLE.
  - A subsequent E = 1, M = 8 decodes to 16 at t + 2.
- **Round trip.** For all B in 0 … 2047, encode canonically, decode, and compare.
  - Expect `out_b` = B with its low E bits cleared, and `out_noncanon` = 0 for every code.
  - Run with random `out_ready` and `in_valid` gaps.

Source files
------------

// File: rtl/float_fmt_pkg.sv
// Shared definitions for the small-float code format: field widths,
// decoder FSM states and the packed {e, m} code used by encoder and decoder.
package float_fmt_pkg;

  localparam int MW = 4;
  localparam int EW = 3;
  localparam int BW = 11;

  // The widest value is a full mantissa shifted by the largest exponent.
  localparam bit FMT_OK = (BW == MW + (1 << EW) - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [EW-1:0] e;
    logic [MW-1:0] m;
  } float_code_t;

endpackage

// File: rtl/float2int_serial.sv
// Serial small-float decoder: B = M << E, shifted one bit per cycle behind
// valid/ready handshakes on both sides.
module float2int_serial #(
  parameter int MW = float_fmt_pkg::MW,
  parameter int EW = float_fmt_pkg::EW,
  parameter int BW = float_fmt_pkg::BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] in_e,
  input  logic [MW-1:0] in_m,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_b,
  output logic          out_noncanon
);
  import float_fmt_pkg::*;

  if (BW != MW + (1 << EW) - 1) begin : g_bw_check
    $error("float2int_serial: BW must equal MW + 2**EW - 1");
  end
  if (!FMT_OK) begin : g_pkg_check
    $error("float_fmt_pkg: BW must equal MW + 2**EW - 1");
  end

  state_e        state_q, state_d;
  logic [BW-1:0] acc_q, acc_d;
  logic [EW-1:0] cnt_q, cnt_d;
  logic          nc_q, nc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      nc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      nc_q    <= nc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    nc_d      = nc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = !rst;
        if (in_valid) begin
          acc_d   = {{(BW-MW){1'b0}}, in_m};
          cnt_d   = in_e;
          // A canonical code with a nonzero exponent always has its mantissa MSB set.
          nc_d    = (in_e != '0) && !in_m[MW-1];
          state_d = (in_e == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = acc_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == EW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_b        = acc_q;
  assign out_noncanon = nc_q;

endmodule
